// File: rtl/trigger_pkg.sv
// trigger_pkg: shared types, register map and defaults for the trigger sequencer
package trigger_pkg;
  typedef enum logic [1:0] {IDLE, ARMING, RUNNING, STOPPING} state_t;
  localparam logic [2:0] A_RATE = 3'd0, A_PULSE = 3'd1, A_DELAY0 = 3'd2, A_DELAY3 = 3'd5, A_COMMIT = 3'd6;
  localparam int TRIG_MAX_RATE = 120;
  localparam int TRIG_DEF_RATE = 30;
  localparam int TRIG_DEF_PULSE = 2000;
  localparam int TRIG_STOP_GUARD = 256;
  typedef struct packed {
    logic [7:0] rate;
    logic [15:0] pulse_width;
    logic [3:0][7:0] delay;
  } trig_cfg_t;
endpackage

// File: rtl/trigger_sequencer_if.sv
// trigger_sequencer_if: host configuration write channel
interface trigger_sequencer_if;
  logic cfg_valid, cfg_ready, cfg_error;
  logic [2:0] cfg_addr;
  logic [15:0] cfg_data;
  modport master(output cfg_valid, cfg_addr, cfg_data, input cfg_ready, cfg_error);
  modport slave(input cfg_valid, cfg_addr, cfg_data, output cfg_ready, cfg_error);
endinterface

// File: rtl/trig_edge_detect.sv
// trig_edge_detect: registered rise/fall detection of the generator trigger
module trig_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic rise,
  output logic fall
);
  logic trig_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) trig_q <= 1'b0;
    else trig_q <= trig;
  assign rise = trig & ~trig_q;
  assign fall = ~trig & trig_q;
endmodule

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: shadowed trigger config with frame-boundary commit and start/stop/burst sequencing
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int MAX_FRAME_RATE = TRIG_MAX_RATE,
  parameter int DEFAULT_RATE = TRIG_DEF_RATE,
  parameter int DEFAULT_PULSE = TRIG_DEF_PULSE,
  parameter int STOP_GUARD = TRIG_STOP_GUARD
) (
  input  logic clk,
  input  logic rst_n,
  trigger_sequencer_if.slave cfg,
  input  logic cmd_start,
  input  logic cmd_stop,
  input  logic [15:0] burst_len,
  input  logic trig_mon,
  output logic gen_enable,
  output logic [7:0] gen_frame_rate,
  output logic [15:0] gen_pulse_width,
  output logic [31:0] gen_delay,
  output logic [1:0] state,
  output logic [31:0] frame_count,
  output logic cfg_pending,
  output logic done
);
  localparam int GW = $clog2(STOP_GUARD + 1);
  localparam trig_cfg_t RST_CFG = '{rate: 8'(DEFAULT_RATE), pulse_width: 16'(DEFAULT_PULSE), delay: '0};
  state_t st, st_d;
  trig_cfg_t shadow, active;
  logic [15:0] burst_q;
  logic [GW-1:0] guard;
  logic [31:0] count_inc;
  logic [1:0] di;
  logic rise, fall, wr, bad, commit, start_go, apply;
  trig_edge_detect u_edge (.clk(clk), .rst_n(rst_n), .trig(trig_mon), .rise(rise), .fall(fall));
  assign cfg.cfg_ready = ~cfg_pending;
  assign wr = cfg.cfg_valid & cfg.cfg_ready;
  assign commit = wr & cfg.cfg_addr == A_COMMIT;
  assign di = 2'(cfg.cfg_addr - A_DELAY0);
  assign bad = wr & (cfg.cfg_addr == 3'd7
    | (cfg.cfg_addr == A_RATE & (cfg.cfg_data[7:0] == 8'd0 | cfg.cfg_data[7:0] > 8'(MAX_FRAME_RATE)))
    | (cfg.cfg_addr == A_PULSE & cfg.cfg_data == 16'd0));
  assign count_inc = frame_count + 32'd1;
  assign start_go = st == IDLE & st_d == ARMING;
  // a deferred commit lands only once the current pulse has ended, or at start
  assign apply = cfg_pending & (fall | start_go);
  assign state = st;
  assign gen_frame_rate = active.rate;
  assign gen_pulse_width = active.pulse_width;
  assign gen_delay = active.delay;
  always_comb begin
    st_d = st;
    case (st)
      IDLE:     st_d = cmd_start & ~cmd_stop ? ARMING : IDLE;
      ARMING:   st_d = cmd_stop ? STOPPING : RUNNING;
      RUNNING:  st_d = cmd_stop | (rise & burst_q != 16'd0 & count_inc == 32'(burst_q)) ? STOPPING : RUNNING;
      STOPPING: st_d = ~trig_mon & guard == GW'(STOP_GUARD) ? IDLE : STOPPING;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      shadow <= RST_CFG;
      active <= RST_CFG;
      cfg_pending <= 1'b0;
      cfg.cfg_error <= 1'b0;
      done <= 1'b0;
      gen_enable <= 1'b0;
      frame_count <= '0;
      burst_q <= '0;
      guard <= '0;
    end else begin
      st <= st_d;
      cfg.cfg_error <= bad;
      done <= st == STOPPING & st_d == IDLE;
      gen_enable <= st_d == RUNNING | (gen_enable & st_d != IDLE);
      guard <= st == STOPPING & ~trig_mon ? guard + 1'b1 : '0;
      if (start_go) frame_count <= '0;
      else if (st == RUNNING & rise) frame_count <= count_inc;
      if (start_go) burst_q <= burst_len;
      if (wr & ~bad & cfg.cfg_addr == A_RATE) shadow.rate <= cfg.cfg_data[7:0];
      if (wr & ~bad & cfg.cfg_addr == A_PULSE) shadow.pulse_width <= cfg.cfg_data;
      if (wr & cfg.cfg_addr >= A_DELAY0 & cfg.cfg_addr <= A_DELAY3) shadow.delay[di] <= cfg.cfg_data[7:0];
      if ((commit & st == IDLE) | apply) active <= shadow;
      cfg_pending <= (commit & st != IDLE) | (cfg_pending & ~apply);
    end
endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: table-driven config checks plus directed run/stop/reset sequences
module tb_trigger_sequencer;
  import trigger_pkg::*;
  typedef struct {
    logic [2:0] a;
    logic [15:0] d;
    logic err;
    logic [7:0] rate;
    logic [15:0] pw;
    logic [31:0] dly;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_start = 1'b0, cmd_stop = 1'b0, trig_mon = 1'b0;
  logic [15:0] burst_len = '0;
  logic gen_enable, cfg_pending, done;
  logic [7:0] gen_frame_rate;
  logic [15:0] gen_pulse_width;
  logic [31:0] gen_delay, frame_count;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  vec_t v[10];
  always #5 clk = ~clk;
  trigger_sequencer_if bus();
  trigger_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg(bus), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .burst_len(burst_len), .trig_mon(trig_mon), .gen_enable(gen_enable),
    .gen_frame_rate(gen_frame_rate), .gen_pulse_width(gen_pulse_width), .gen_delay(gen_delay),
    .state(state), .frame_count(frame_count), .cfg_pending(cfg_pending), .done(done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    step(1);
    bus.cfg_valid = 1'b0;
  endtask
  // bounded watch of the stop guard: first cycle back in IDLE, done pulses, enable-high cycles
  task automatic watch_stop(output int cyc, output int dn, output int eh);
    cyc = -1; dn = 0; eh = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (done) dn++;
      if (gen_enable) eh++;
      if (state == 2'd0 && cyc < 0) cyc = i + 1;
    end
  endtask
  initial begin
    int cyc, dn, eh;
    logic [7:0] pr;
    logic [15:0] pp;
    logic [31:0] pd;
    bus.cfg_valid = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    v[0] = '{3'd0, 16'd0,     1'b1, 8'd30,  16'd2000, 32'h0};
    v[1] = '{3'd0, 16'd121,   1'b1, 8'd30,  16'd2000, 32'h0};
    v[2] = '{3'd0, 16'd60,    1'b0, 8'd60,  16'd2000, 32'h0};
    v[3] = '{3'd0, 16'd120,   1'b0, 8'd120, 16'd2000, 32'h0};
    v[4] = '{3'd0, 16'h0100,  1'b1, 8'd120, 16'd2000, 32'h0};
    v[5] = '{3'd1, 16'd0,     1'b1, 8'd120, 16'd2000, 32'h0};
    v[6] = '{3'd1, 16'd500,   1'b0, 8'd120, 16'd500,  32'h0};
    v[7] = '{3'd2, 16'h0011,  1'b0, 8'd120, 16'd500,  32'h0000_0011};
    v[8] = '{3'd5, 16'hAB44,  1'b0, 8'd120, 16'd500,  32'h4400_0011};
    v[9] = '{3'd7, 16'h0005,  1'b1, 8'd120, 16'd500,  32'h4400_0011};
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("rst_state", 32'(state), 0);
    chk("rst_enable", 32'(gen_enable), 0);
    chk("rst_rate", 32'(gen_frame_rate), 30);
    chk("rst_pulse", 32'(gen_pulse_width), 2000);
    chk("rst_delay", gen_delay, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_ready", 32'(bus.cfg_ready), 1);
    chk("rst_err_done_pend", 32'({bus.cfg_error, done, cfg_pending}), 0);
    pr = 8'd30; pp = 16'd2000; pd = 32'h0;
    for (int i = 0; i < 10; i++) begin
      wr(v[i].a, v[i].d);
      chk($sformatf("v%0d_err", i), 32'(bus.cfg_error), 32'(v[i].err));
      chk($sformatf("v%0d_no_direct", i), {gen_frame_rate, gen_delay[23:0]}, {pr, pd[23:0]});
      chk($sformatf("v%0d_no_direct_pw", i), 32'(gen_pulse_width), 32'(pp));
      wr(A_COMMIT, 16'd0);
      chk($sformatf("v%0d_commit_err", i), 32'(bus.cfg_error), 0);
      chk($sformatf("v%0d_pending", i), 32'(cfg_pending), 0);
      chk($sformatf("v%0d_rate", i), 32'(gen_frame_rate), 32'(v[i].rate));
      chk($sformatf("v%0d_pulse", i), 32'(gen_pulse_width), 32'(v[i].pw));
      chk($sformatf("v%0d_delay", i), gen_delay, v[i].dly);
      pr = v[i].rate; pp = v[i].pw; pd = v[i].dly;
    end
    // burst of three frames, then the stop guard
    burst_len = 16'd3;
    cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    chk("burst_arming", 32'(state), 1);
    chk("burst_arming_en", 32'(gen_enable), 0);
    step(1);
    chk("burst_running", 32'(state), 2);
    chk("burst_en", 32'(gen_enable), 1);
    for (int p = 0; p < 2; p++) begin
      trig_mon = 1'b1; step(4);
      trig_mon = 1'b0; step(6);
    end
    chk("burst_count2", frame_count, 2);
    chk("burst_state2", 32'(state), 2);
    trig_mon = 1'b1;
    step(1);
    chk("burst_count3", frame_count, 3);
    chk("burst_stopping", 32'(state), 3);
    step(3);
    trig_mon = 1'b0;
    step(256);
    chk("guard_en_held", 32'(gen_enable), 1);
    chk("guard_no_done", 32'(done), 0);
    step(1);
    chk("guard_en_fall", 32'(gen_enable), 0);
    chk("guard_done", 32'(done), 1);
    chk("guard_idle", 32'(state), 0);
    step(1);
    chk("guard_done_once", 32'(done), 0);
    // deferred commit mid-pulse in continuous mode
    burst_len = 16'd0;
    cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    chk("cont_count_clr", frame_count, 0);
    step(1);
    trig_mon = 1'b1;
    cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    chk("start_ignored", 32'(state), 2);
    chk("cont_count1", frame_count, 1);
    wr(A_PULSE, 16'd900);
    chk("pend_wr_err", 32'(bus.cfg_error), 0);
    wr(A_COMMIT, 16'd0);
    chk("pend_set", 32'(cfg_pending), 1);
    chk("pend_ready", 32'(bus.cfg_ready), 0);
    chk("pend_pw_hold", 32'(gen_pulse_width), 500);
    step(2);
    chk("pend_pw_hold2", 32'(gen_pulse_width), 500);
    trig_mon = 1'b0;
    step(1);
    chk("pend_pw_apply", 32'(gen_pulse_width), 900);
    chk("pend_clear", 32'(cfg_pending), 0);
    chk("pend_ready_back", 32'(bus.cfg_ready), 1);
    cmd_stop = 1'b1;
    step(1);
    cmd_stop = 1'b0;
    chk("stop_state", 32'(state), 3);
    watch_stop(cyc, dn, eh);
    chk("stop_idle_cycle", 32'(cyc), 257);
    chk("stop_done_once", 32'(dn), 1);
    // start+stop together in IDLE, then stop during ARMING
    cmd_start = 1'b1;
    cmd_stop = 1'b1;
    step(2);
    chk("startstop_idle", 32'(state), 0);
    cmd_stop = 1'b0;
    step(1);
    cmd_start = 1'b0;
    chk("arm_state", 32'(state), 1);
    cmd_stop = 1'b1;
    step(1);
    cmd_stop = 1'b0;
    chk("arm_stop_state", 32'(state), 3);
    watch_stop(cyc, dn, eh);
    chk("arm_stop_no_en", 32'(eh), 0);
    chk("arm_stop_done", 32'(dn), 1);
    chk("arm_stop_cycle", 32'(cyc), 257);
    // asynchronous reset while running with a commit pending
    cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    step(1);
    trig_mon = 1'b1;
    step(1);
    chk("rr_count", frame_count, 1);
    wr(A_RATE, 16'd77);
    wr(A_COMMIT, 16'd0);
    chk("rr_pending", 32'(cfg_pending), 1);
    rst_n = 1'b0;
    #1;
    chk("rr_en", 32'(gen_enable), 0);
    chk("rr_count0", frame_count, 0);
    chk("rr_pend0", 32'(cfg_pending), 0);
    chk("rr_state", 32'(state), 0);
    chk("rr_rate", 32'(gen_frame_rate), 30);
    chk("rr_pulse", 32'(gen_pulse_width), 2000);
    chk("rr_delay", gen_delay, 0);
    trig_mon = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    wr(A_COMMIT, 16'd0);
    chk("rr_shadow_rate", 32'(gen_frame_rate), 30);
    chk("rr_shadow_pulse", 32'(gen_pulse_width), 2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
